// File: rtl/spram_ctrl_pkg.sv
// Shared definitions for the single-port RAM burst sequencer: FSM states,
// read-buffer depth and the read-issue admission check.
package spram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int FIFO_DEPTH = 2;

  // A new read may issue only if the word it returns is guaranteed a FIFO slot.
  function automatic logic fifo_has_room(input logic full, input logic empty,
                                         input logic inflight, input logic pop);
    logic [2:0] occ;
    occ = full ? 3'd2 : (empty ? 3'd0 : 3'd1);
    return (occ + {2'b00, inflight}) < (3'(FIFO_DEPTH) + {2'b00, pop});
  endfunction

endpackage

// File: rtl/spram_rd_skid_fifo.sv
// Two-entry output buffer absorbing RAM read data while the consumer stalls.
module spram_rd_skid_fifo
  import spram_ctrl_pkg::*;
#(
  parameter int DWIDTH = 60
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic              pop,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] dout,
  output logic              full,
  output logic              empty
);

  logic [DWIDTH-1:0] buf_q [FIFO_DEPTH];
  logic              wp;
  logic              rp;
  logic [1:0]        cnt;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (cnt == 2'(FIFO_DEPTH));
  assign empty   = (cnt == 2'd0);
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign dout    = buf_q[rp];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push_ok) wp <= ~wp;
      if (pop_ok)  rp <= ~rp;
      cnt <= cnt + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) buf_q[wp] <= din;
  end

endmodule

// File: rtl/spram_seq_ctrl.sv
// Burst sequencer for a single-port RAM: streams write bursts into the RAM and
// read bursts out through a two-entry buffer with full back-pressure support.
module spram_seq_ctrl
  import spram_ctrl_pkg::*;
#(
  parameter int AWIDTH    = 12,
  parameter int DWIDTH    = 60,
  parameter int NUM_WORDS = 4096
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [AWIDTH-1:0] cmd_base,
  input  logic [AWIDTH:0]   cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DWIDTH-1:0] rd_data,
  output logic              done,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_wren,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);

  localparam logic [AWIDTH:0] MAX_LEN = (AWIDTH+1)'(NUM_WORDS);

  state_t            state;
  logic [AWIDTH-1:0] addr_q;
  logic [AWIDTH:0]   cnt_q;
  logic [AWIDTH:0]   len_eff;
  logic              vld_p1;
  logic              done_q;
  logic              issue;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;

  assign len_eff   = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
  assign cmd_ready = (state == ST_IDLE);
  assign wr_ready  = (state == ST_WRITE);
  assign mem_wren  = wr_ready && wr_valid;
  assign mem_wdata = wr_data;
  assign mem_addr  = addr_q;
  assign done      = done_q;
  assign rd_valid  = !fifo_empty;
  assign pop       = rd_valid && rd_ready;
  assign issue     = (state == ST_READ) && (cnt_q != '0) &&
                     fifo_has_room(fifo_full, fifo_empty, vld_p1, pop);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      cnt_q  <= '0;
      vld_p1 <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // p0 -> p1: a read issued this cycle returns data from the RAM next cycle
      vld_p1 <= issue;
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (len_eff == '0) begin
              done_q <= 1'b1;
            end else begin
              addr_q <= cmd_base;
              cnt_q  <= len_eff;
              state  <= cmd_op ? ST_READ : ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (wr_valid) begin
            addr_q <= addr_q + AWIDTH'(1);
            cnt_q  <= cnt_q - (AWIDTH+1)'(1);
            if (cnt_q == (AWIDTH+1)'(1)) begin
              state  <= ST_IDLE;
              done_q <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (issue) begin
            addr_q <= addr_q + AWIDTH'(1);
            cnt_q  <= cnt_q - (AWIDTH+1)'(1);
            if (cnt_q == (AWIDTH+1)'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Last word leaves when nothing is in flight and it is the only one buffered
          if (pop && !vld_p1 && !fifo_full) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  spram_rd_skid_fifo #(
    .DWIDTH (DWIDTH)
  ) u_rd_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (vld_p1),
    .pop    (pop),
    .din    (mem_rdata),
    .dout   (rd_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_spram_seq_ctrl.sv
// Self-checking bench for spram_seq_ctrl with a behavioural RAM and an
// array-based reference of RAM contents.
module tb_spram_seq_ctrl;

  localparam int AW = 12;
  localparam int DW = 60;
  localparam int NW = 4096;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [AW-1:0] cmd_base;
  logic [AW:0]   cmd_len;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic          mem_wren;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] ram     [NW];
  logic [DW-1:0] ref_mem [NW];
  logic [DW-1:0] wq [$];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Single-port RAM: registered read, output held during a write
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr] <= mem_wdata;
    else          mem_rdata     <= ram[mem_addr];
  end

  spram_seq_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .NUM_WORDS(NW)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int base, input int len, input bit gaps, input bit use_q);
    int i = 0;
    int cyc = 0;
    int a;
    logic [63:0] r;
    cmd_op = 1'b0; cmd_base = AW'(base); cmd_len = (AW+1)'(len); cmd_valid = 1'b1;
    @(negedge clk);
    chk("wr_cmd_ready", 64'(cmd_ready), 64'(1));
    next_cycle();
    cmd_valid = 1'b0;
    while (i < len && cyc < len * 4 + 20) begin
      cyc++;
      wr_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      r = {$urandom, $urandom};
      wr_data = use_q ? wq[i] : r[DW-1:0];
      @(negedge clk);
      chk("wr_ready", 64'(wr_ready), 64'(1));
      chk("wr_wren", 64'(mem_wren), 64'(wr_valid));
      if (wr_valid) begin
        a = (base + i) % NW;
        chk("wr_addr", 64'(mem_addr), 64'(a));
        chk("wr_wdata", 64'(mem_wdata), 64'(wr_data));
        ref_mem[a] = wr_data;
        i++;
      end
      if (done) chk("wr_early_done", 64'(done), 64'(0));
      next_cycle();
    end
    wr_valid = 1'b0;
    chk("wr_count", 64'(i), 64'(len));
    if (!gaps) chk("wr_cycles", 64'(cyc), 64'(len));
    @(negedge clk);
    chk("wr_done", 64'(done), 64'(1));
    chk("wr_idle", 64'(cmd_ready), 64'(1));
    chk("wr_ready_off", 64'(wr_ready), 64'(0));
    chk("wr_wren_off", 64'(mem_wren), 64'(0));
    next_cycle();
    @(negedge clk);
    chk("wr_done_once", 64'(done), 64'(0));
    next_cycle();
  endtask

  task automatic do_read(input int base, input int len, input int mode, input bit poke);
    logic [DW-1:0] exp_q [$];
    int got = 0;
    int cyc = 0;
    int first_cyc = -1;
    int last_cyc = -1;
    for (int i = 0; i < len; i++) exp_q.push_back(ref_mem[(base + i) % NW]);
    cmd_op = 1'b1; cmd_base = AW'(base); cmd_len = (AW+1)'(len); cmd_valid = 1'b1;
    @(negedge clk);
    chk("rd_cmd_ready", 64'(cmd_ready), 64'(1));
    next_cycle();
    cmd_valid = 1'b0;
    while (got < len && cyc < len * 4 + 20) begin
      cyc++;
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
        default: rd_ready = ($urandom_range(0, 1) == 1);
      endcase
      cmd_valid = poke && (cyc <= 3);
      cmd_op = 1'b0; cmd_len = (AW+1)'(1);
      @(negedge clk);
      if (poke && cyc <= 3) chk("rd_cmd_ignored", 64'(cmd_ready), 64'(0));
      if (rd_valid && rd_ready) begin
        chk("rd_data", 64'(rd_data), 64'(exp_q[got]));
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
      end
      if (mem_wren) chk("rd_no_wren", 64'(mem_wren), 64'(0));
      if (done) chk("rd_early_done", 64'(done), 64'(0));
      next_cycle();
    end
    cmd_valid = 1'b0;
    rd_ready = 1'b0;
    chk("rd_count", 64'(got), 64'(len));
    if (mode == 0) begin
      chk("rd_latency", 64'(first_cyc), 64'(3));
      chk("rd_throughput", 64'(last_cyc - first_cyc), 64'(len - 1));
    end
    @(negedge clk);
    chk("rd_done", 64'(done), 64'(1));
    chk("rd_idle", 64'(cmd_ready), 64'(1));
    next_cycle();
    @(negedge clk);
    chk("rd_done_once", 64'(done), 64'(0));
    chk("rd_no_extra", 64'(rd_valid), 64'(0));
    next_cycle();
  endtask

  initial begin
    logic [AW-1:0] saved_addr;
    logic [DW-1:0] exp_q [$];
    int b;
    int l;
    resetn = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_base = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

    // Reset state
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_wr_ready", 64'(wr_ready), 64'(0));
    chk("rst_wren", 64'(mem_wren), 64'(0));
    chk("rst_addr", 64'(mem_addr), 64'(0));
    next_cycle();
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    next_cycle();

    // Basic write/read of 0xA..0xD
    wq = '{60'hA, 60'hB, 60'hC, 60'hD};
    do_write(0, 4, 1'b0, 1'b1);
    do_read(0, 4, 0, 1'b0);
    chk("ref_word3", 64'(ref_mem[3]), 64'hD);

    // Wrap across the top of the address space
    do_write(4094, 3, 1'b0, 1'b0);
    do_read(4094, 3, 0, 1'b0);

    // Stalling consumer plus commands offered while busy
    do_write(200, 8, 1'b1, 1'b0);
    do_read(200, 8, 1, 1'b1);

    // Zero-length command
    cmd_op = 1'b0; cmd_base = AW'(777); cmd_len = '0; cmd_valid = 1'b1;
    @(negedge clk);
    chk("z_cmd_ready", 64'(cmd_ready), 64'(1));
    saved_addr = mem_addr;
    next_cycle();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("z_done", 64'(done), 64'(1));
    chk("z_wren", 64'(mem_wren), 64'(0));
    chk("z_addr", 64'(mem_addr), 64'(saved_addr));
    chk("z_idle", 64'(cmd_ready), 64'(1));
    next_cycle();
    @(negedge clk);
    chk("z_done_once", 64'(done), 64'(0));
    chk("z_addr_hold", 64'(mem_addr), 64'(saved_addr));
    next_cycle();

    // Random bursts with random write gaps and random back-pressure
    for (int k = 0; k < 5; k++) begin
      b = $urandom_range(0, NW - 1);
      l = $urandom_range(1, 20);
      do_write(b, l, 1'b1, 1'b0);
      do_read(b, l, 2, 1'b0);
    end

    // Reset in the middle of a read burst
    do_write(100, 16, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) exp_q.push_back(ref_mem[100 + i]);
    cmd_op = 1'b1; cmd_base = AW'(100); cmd_len = (AW+1)'(16); cmd_valid = 1'b1;
    next_cycle();
    cmd_valid = 1'b0;
    rd_ready = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c >= 3) chk("mr_data", 64'(rd_data), 64'(exp_q[c - 3]));
      next_cycle();
    end
    resetn = 1'b0;
    next_cycle();
    resetn = 1'b1;
    @(negedge clk);
    chk("mr_rd_valid", 64'(rd_valid), 64'(0));
    chk("mr_done", 64'(done), 64'(0));
    chk("mr_idle", 64'(cmd_ready), 64'(1));
    chk("mr_wren", 64'(mem_wren), 64'(0));
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      @(negedge clk);
      chk("mr_quiet_done", 64'(done), 64'(0));
      chk("mr_quiet_valid", 64'(rd_valid), 64'(0));
    end
    next_cycle();
    rd_ready = 1'b0;
    do_read(100, 16, 0, 1'b0);

    // Whole RAM once, starting at a random base
    b = $urandom_range(0, NW - 1);
    do_write(b, NW, 1'b0, 1'b0);
    do_read(b, NW, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spram_seq_ctrl.md
SPRAM_SEQ_CTRL -- requirements
Module: spram_seq_ctrl

Interface
REQ-001 SHALL have parameter AWIDTH, default 12, RAM address width.
REQ-002 SHALL have parameter DWIDTH, default 60, RAM word width.
REQ-003 SHALL have parameter NUM_WORDS, default 4096, RAM depth (2**AWIDTH).
REQ-004 SHALL use one clock; reset is synchronous and active-low. Ports: clk  in  1  rising-edge clock; resetn  in  1  synchronous active-low reset.
REQ-005 cmd_valid  in  1  command offered; cmd_ready  out  1  command accepted when both high.
REQ-006 cmd_op  in  1  0 = write burst, 1 = read burst; cmd_base  in  AWIDTH  start address; cmd_len  in  AWIDTH+1  word count, 0..NUM_WORDS.
REQ-007 wr_valid  in  1; wr_ready  out  1; wr_data  in  DWIDTH  write stream.
REQ-008 rd_valid  out  1; rd_ready  in  1; rd_data  out  DWIDTH  read stream.
REQ-009 done  out  1  one-cycle pulse at burst completion.
REQ-010 mem_addr  out  AWIDTH; mem_wren  out  1; mem_wdata  out  DWIDTH; mem_rdata  in  DWIDTH  single-port RAM side; RAM registers read data one cycle after address, holds output during writes.

Function
REQ-011 States SHALL be IDLE, WRITE, READ, DRAIN; cmd_ready = 1 only in IDLE.
REQ-012 Command accept: cmd_len 0 -> stay IDLE, done pulses next cycle, no RAM access; op 0 -> WRITE; op 1 -> READ; address counter loads cmd_base, remaining count loads cmd_len.
REQ-013 WRITE: wr_ready = 1; mem_wren = wr_valid; mem_addr = address counter; mem_wdata = wr_data (combinational pass-through).
REQ-014 WRITE: each wr handshake increments address and decrements count; after last handshake -> IDLE with done pulse the following cycle.
REQ-015 Outside WRITE: wr_ready = 0, mem_wren = 0.
REQ-016 READ: a read issues (mem_addr = counter, counter increments) when count remaining > 0 and fifo occupancy + in-flight - pop_this_cycle < 2.
REQ-017 mem_rdata SHALL be pushed into 2-entry output FIFO exactly one cycle after its issue; no data loss or duplication under any rd_ready pattern.
REQ-018 rd_valid = FIFO non-empty; rd_data = FIFO head; pop on rd_valid & rd_ready.
REQ-019 Latency: first rd_valid two cycles after the accepting edge; sustained throughput 1 word/cycle when rd_ready held high, in both WRITE and READ.
REQ-020 After last issue -> DRAIN; DRAIN -> IDLE when final word popped; done pulses in the cycle after that pop.
REQ-021 Address SHALL wrap modulo NUM_WORDS (4095 + 1 -> 0); cmd_len = NUM_WORDS covers the full RAM once.
REQ-022 cmd_valid outside IDLE SHALL be ignored (not accepted, no effect).

Reset
REQ-023 resetn low at a clock edge: state IDLE, counters 0, FIFO empty, in-flight cleared; done, rd_valid, wr_ready, mem_wren = 0; cmd_ready = 1 after release.
REQ-024 Reset mid-burst SHALL abort the burst without a done pulse; RAM contents not altered or cleared.

Structure
REQ-025 Shared package spram_ctrl_pkg SHALL hold the state enum and FIFO depth constant (2).
REQ-026 Output buffering SHALL be a sub-module spram_rd_skid_fifo (2-entry, push/pop/full/empty, synchronous active-low reset).

Verification
REQ-027 Write base 0, len 4, data 0xA..0xD, wr_valid constant -> mem_wren 4 cycles, addr 0..3, done once.
REQ-028 Read base 0, len 4, rd_ready = 1 -> rd_data 0xA,0xB,0xC,0xD on consecutive cycles, first 2 cycles after accept, done once.
REQ-029 Write base 4094, len 3 then read same -> addresses 4094, 4095, 0; data round-trips.
REQ-030 Read len 8 with rd_ready toggling 1,0,0,1 pattern -> all 8 words in order, never more than 2 buffered, no duplicates.
REQ-031 cmd_len 0 -> done next cycle, mem_wren and mem_addr activity absent; cmd_valid during READ ignored.
REQ-032 resetn low mid-read of len 16 -> rd_valid 0 next cycle, no done, IDLE; new read returns pre-reset written data.
